// File: rtl/leve1_pkg.sv
// rtl/leve1_pkg.sv - shared register-file widths and long-result queue entry type
`ifndef XLEN
`define XLEN 32
`endif

package leve1_pkg;
    localparam int REG_AW  = 5;
    localparam int NUM_REG = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [`XLEN-1:0]  wd;
    } lq_entry_t;
endpackage

// File: rtl/leve1_fifo.sv
// rtl/leve1_fifo.sv - small synchronous FIFO used as the long-result queue
module leve1_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic CLK,
    input  logic RST,
    input  logic PUSH,
    input  T     PUSH_DATA,
    input  logic POP,
    output T     POP_DATA,
    output logic EMPTY,
    output logic FULL
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign EMPTY    = (count == '0);
    assign FULL     = (count == FULL_CNT);
    assign do_push  = PUSH && !FULL;
    assign do_pop   = POP && !EMPTY;
    assign POP_DATA = mem[rd_ptr];

    // Storage carries no reset; an empty count is enough to make it invisible.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= PUSH_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/leve1_rf_arb.sv
// rtl/leve1_rf_arb.sv - register-file write arbiter with long-latency scoreboard and issue stall
module leve1_rf_arb
    import leve1_pkg::*;
#(
    parameter int XLEN     = `XLEN,
    parameter int LQ_DEPTH = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              P_VALID,
    input  logic [REG_AW-1:0] P_RD,
    input  logic [XLEN-1:0]   P_WD,
    input  logic              L_VALID,
    output logic              L_READY,
    input  logic [REG_AW-1:0] L_RD,
    input  logic [XLEN-1:0]   L_WD,
    input  logic              ISS_VALID,
    input  logic              ISS_LONG,
    input  logic [REG_AW-1:0] ISS_RS1,
    input  logic [REG_AW-1:0] ISS_RS2,
    input  logic [REG_AW-1:0] ISS_RD,
    output logic              STALL,
    output logic              RF_WE,
    output logic [REG_AW-1:0] RF_WA,
    output logic [XLEN-1:0]   RF_WD,
    output logic              ERR
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    logic [NUM_REG-1:0] sb;
    logic [NUM_REG-1:0] sb_next;
    logic [CW-1:0]      out_cnt;
    logic               rf_long;
    lq_entry_t          lq_in;
    lq_entry_t          lq_head;
    logic               lq_empty;
    logic               lq_full;
    logic               l_acc;
    logic               sel_q;
    logic               sel_l;
    logic               lq_push;
    logic               long_issue;
    logic               sel_any;
    logic               sel_long;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_wd;
    logic               miss_err;
    logic               underflow;

    assign L_READY = !RST && !lq_full;
    assign l_acc   = L_VALID && L_READY;
    assign sel_q   = !P_VALID && !lq_empty;
    assign sel_l   = !P_VALID && lq_empty && l_acc;
    assign lq_push = l_acc && !sel_l;
    assign lq_in   = '{rd: L_RD, wd: L_WD};

    leve1_fifo #(
        .DEPTH (LQ_DEPTH),
        .T     (lq_entry_t)
    ) u_lq (
        .CLK       (CLK),
        .RST       (RST),
        .PUSH      (lq_push),
        .PUSH_DATA (lq_in),
        .POP       (sel_q),
        .POP_DATA  (lq_head),
        .EMPTY     (lq_empty),
        .FULL      (lq_full)
    );

    // Only current-cycle state feeds STALL, so a result arriving this cycle cannot release it.
    assign STALL = !RST && ISS_VALID &&
                   (sb[ISS_RS1] || sb[ISS_RS2] || sb[ISS_RD] ||
                    (ISS_LONG && out_cnt == MAX_CNT));
    assign long_issue = ISS_VALID && ISS_LONG && !STALL;

    always_comb begin
        sel_any  = 1'b1;
        sel_long = 1'b0;
        sel_rd   = P_RD;
        sel_wd   = P_WD;
        if (P_VALID) begin
            sel_long = 1'b0;
        end else if (sel_q) begin
            sel_long = 1'b1;
            sel_rd   = lq_head.rd;
            sel_wd   = lq_head.wd;
        end else if (sel_l) begin
            sel_long = 1'b1;
            sel_rd   = L_RD;
            sel_wd   = L_WD;
        end else begin
            sel_any  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RF_WE   <= 1'b0;
            RF_WA   <= '0;
            RF_WD   <= '0;
            rf_long <= 1'b0;
        end else begin
            RF_WE   <= sel_any && (sel_rd != '0);
            RF_WA   <= sel_rd;
            RF_WD   <= sel_wd;
            rf_long <= sel_any && sel_long;
        end
    end

    // A retiring long write frees its register at the end of the cycle it is on RF_*.
    always_comb begin
        sb_next = sb;
        if (rf_long) sb_next[RF_WA] = 1'b0;
        if (long_issue && ISS_RD != '0) sb_next[ISS_RD] = 1'b1;
        sb_next[0] = 1'b0;
    end

    assign miss_err  = l_acc && (L_RD != '0) && !sb[L_RD];
    assign underflow = rf_long && !long_issue && (out_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sb      <= '0;
            out_cnt <= '0;
            ERR     <= 1'b0;
        end else begin
            sb <= sb_next;
            case ({long_issue, rf_long})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= underflow ? out_cnt : out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (miss_err || underflow) ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_leve1_rf_arb.sv
// tb/tb_leve1_rf_arb.sv - directed self-checking bench for leve1_rf_arb
module tb_leve1_rf_arb;
    logic        CLK;
    logic        RST;
    logic        P_VALID;
    logic [4:0]  P_RD;
    logic [31:0] P_WD;
    logic        L_VALID;
    logic        L_READY;
    logic [4:0]  L_RD;
    logic [31:0] L_WD;
    logic        ISS_VALID;
    logic        ISS_LONG;
    logic [4:0]  ISS_RS1;
    logic [4:0]  ISS_RS2;
    logic [4:0]  ISS_RD;
    logic        STALL;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD;
    logic        ERR;

    int pass_cnt = 0;
    int total_cnt = 0;

    leve1_rf_arb #(.XLEN(32), .LQ_DEPTH(2), .MAX_OUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .P_VALID(P_VALID), .P_RD(P_RD), .P_WD(P_WD),
        .L_VALID(L_VALID), .L_READY(L_READY), .L_RD(L_RD), .L_WD(L_WD),
        .ISS_VALID(ISS_VALID), .ISS_LONG(ISS_LONG), .ISS_RS1(ISS_RS1),
        .ISS_RS2(ISS_RS2), .ISS_RD(ISS_RD), .STALL(STALL),
        .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        P_VALID = 0; P_RD = 0; P_WD = 0;
        L_VALID = 0; L_RD = 0; L_WD = 0;
        ISS_VALID = 0; ISS_LONG = 0; ISS_RS1 = 0; ISS_RS2 = 0; ISS_RD = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        ISS_VALID = 1; ISS_LONG = 1; ISS_RS1 = 0; ISS_RS2 = 0; ISS_RD = rd;
        tick();
        ISS_VALID = 0; ISS_LONG = 0; ISS_RD = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        ISS_VALID = 1; ISS_RS1 = 5;
        tick(); tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b0) $display("FAIL reset_rf_we: got %0b want 0", RF_WE); else pass_cnt++;
        total_cnt++; if (RF_WA !== 5'd0) $display("FAIL reset_rf_wa: got %0d want 0", RF_WA); else pass_cnt++;
        total_cnt++; if (RF_WD !== 32'd0) $display("FAIL reset_rf_wd: got %h want 0", RF_WD); else pass_cnt++;
        total_cnt++; if (ERR !== 1'b0) $display("FAIL reset_err: got %0b want 0", ERR); else pass_cnt++;
        total_cnt++; if (L_READY !== 1'b0) $display("FAIL reset_l_ready: got %0b want 0", L_READY); else pass_cnt++;
        total_cnt++; if (STALL !== 1'b0) $display("FAIL reset_stall: got %0b want 0", STALL); else pass_cnt++;
        clear_inputs();
        RST = 0;
        settle();
        total_cnt++; if (L_READY !== 1'b1) $display("FAIL post_reset_l_ready: got %0b want 1", L_READY); else pass_cnt++;
    endtask

    task automatic test_raw_stall();
        ISS_VALID = 1; ISS_LONG = 1; ISS_RD = 5; ISS_RS1 = 1; ISS_RS2 = 2;
        settle();
        total_cnt++; if (STALL !== 1'b0) $display("FAIL raw_first_issue: got %0b want 0", STALL); else pass_cnt++;
        tick();
        ISS_LONG = 0; ISS_RS1 = 5; ISS_RS2 = 0; ISS_RD = 6;
        settle();
        total_cnt++; if (STALL !== 1'b1) $display("FAIL raw_stall: got %0b want 1", STALL); else pass_cnt++;
        L_VALID = 1; L_RD = 5; L_WD = 32'hDEAD;
        settle();
        total_cnt++; if (STALL !== 1'b1) $display("FAIL raw_stall_same_cycle_l: got %0b want 1", STALL); else pass_cnt++;
        tick();
        L_VALID = 0;
        settle();
        total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'd5) $display("FAIL raw_rf_write: got we=%0b wa=%0d want we=1 wa=5", RF_WE, RF_WA); else pass_cnt++;
        total_cnt++; if (RF_WD !== 32'hDEAD) $display("FAIL raw_rf_wd: got %h want dead", RF_WD); else pass_cnt++;
        total_cnt++; if (STALL !== 1'b1) $display("FAIL raw_stall_during_write: got %0b want 1", STALL); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (STALL !== 1'b0) $display("FAIL raw_stall_release: got %0b want 0", STALL); else pass_cnt++;
        total_cnt++; if (ERR !== 1'b0) $display("FAIL raw_err: got %0b want 0", ERR); else pass_cnt++;
        clear_inputs();
        tick();
    endtask

    task automatic test_p_vs_l();
        issue_long(7);
        P_VALID = 1; P_RD = 3; P_WD = 32'h33;
        L_VALID = 1; L_RD = 7; L_WD = 32'h77;
        settle();
        total_cnt++; if (L_READY !== 1'b1) $display("FAIL pl_l_ready_n: got %0b want 1", L_READY); else pass_cnt++;
        tick();
        P_VALID = 0; L_VALID = 0;
        settle();
        total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'd3 || RF_WD !== 32'h33) $display("FAIL pl_first_x3: got we=%0b wa=%0d wd=%h want 1/3/33", RF_WE, RF_WA, RF_WD); else pass_cnt++;
        total_cnt++; if (L_READY !== 1'b1) $display("FAIL pl_l_ready_n1: got %0b want 1", L_READY); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'd7 || RF_WD !== 32'h77) $display("FAIL pl_second_x7: got we=%0b wa=%0d wd=%h want 1/7/77", RF_WE, RF_WA, RF_WD); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b0) $display("FAIL pl_idle: got %0b want 0", RF_WE); else pass_cnt++;
        total_cnt++; if (ERR !== 1'b0) $display("FAIL pl_err: got %0b want 0", ERR); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [4:0] lrd;
        issue_long(10); issue_long(11); issue_long(12);
        for (int i = 0; i < 4; i++) begin
            lrd = (i < 2) ? 5'(10 + i) : 5'd12;
            P_VALID = 1; P_RD = 5'(i + 1); P_WD = 32'(i);
            L_VALID = 1; L_RD = lrd; L_WD = 32'hA0 + 32'(lrd - 5'd10);
            settle();
            total_cnt++; if (L_READY !== (i < 2)) $display("FAIL bp_l_ready_%0d: got %0b want %0b", i, L_READY, (i < 2)); else pass_cnt++;
            tick();
            settle();
            total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'(i + 1)) $display("FAIL bp_p_write_%0d: got we=%0b wa=%0d want 1/%0d", i, RF_WE, RF_WA, i + 1); else pass_cnt++;
        end
        P_VALID = 0;
        settle();
        total_cnt++; if (L_READY !== 1'b0) $display("FAIL bp_full_after_p: got %0b want 0", L_READY); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (RF_WA !== 5'd10 || RF_WD !== 32'hA0) $display("FAIL bp_q0: got wa=%0d wd=%h want 10/a0", RF_WA, RF_WD); else pass_cnt++;
        total_cnt++; if (L_READY !== 1'b1) $display("FAIL bp_ready_again: got %0b want 1", L_READY); else pass_cnt++;
        tick();
        L_VALID = 0;
        settle();
        total_cnt++; if (RF_WA !== 5'd11 || RF_WD !== 32'hA1) $display("FAIL bp_q1: got wa=%0d wd=%h want 11/a1", RF_WA, RF_WD); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'd12 || RF_WD !== 32'hA2) $display("FAIL bp_q2: got we=%0b wa=%0d wd=%h want 1/12/a2", RF_WE, RF_WA, RF_WD); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b0 || ERR !== 1'b0) $display("FAIL bp_drained: got we=%0b err=%0b want 0/0", RF_WE, ERR); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_max_out();
        issue_long(13); issue_long(14); issue_long(15); issue_long(16);
        ISS_VALID = 1; ISS_LONG = 1; ISS_RD = 17;
        settle();
        total_cnt++; if (STALL !== 1'b1) $display("FAIL max_fifth_stall: got %0b want 1", STALL); else pass_cnt++;
        L_VALID = 1; L_RD = 13; L_WD = 32'h13;
        tick();
        L_VALID = 0;
        settle();
        total_cnt++; if (STALL !== 1'b1) $display("FAIL max_stall_during_write: got %0b want 1", STALL); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (STALL !== 1'b0) $display("FAIL max_stall_release: got %0b want 0", STALL); else pass_cnt++;
        tick();
        ISS_RD = 18;
        settle();
        total_cnt++; if (STALL !== 1'b1) $display("FAIL max_back_to_four: got %0b want 1", STALL); else pass_cnt++;
        clear_inputs();
        for (int r = 14; r <= 17; r++) begin
            L_VALID = 1; L_RD = 5'(r); L_WD = 32'(r);
            tick();
        end
        L_VALID = 0;
        tick(); tick();
        settle();
        total_cnt++; if (ERR !== 1'b0) $display("FAIL max_err: got %0b want 0", ERR); else pass_cnt++;
    endtask

    task automatic test_err();
        L_VALID = 1; L_RD = 9; L_WD = 32'h99;
        tick();
        L_VALID = 0;
        settle();
        total_cnt++; if (ERR !== 1'b1) $display("FAIL err_set: got %0b want 1", ERR); else pass_cnt++;
        total_cnt++; if (RF_WE !== 1'b1 || RF_WA !== 5'd9 || RF_WD !== 32'h99) $display("FAIL err_still_written: got we=%0b wa=%0d wd=%h want 1/9/99", RF_WE, RF_WA, RF_WD); else pass_cnt++;
        L_VALID = 1; L_RD = 0; L_WD = 32'h5;
        tick();
        L_VALID = 0;
        settle();
        total_cnt++; if (RF_WE !== 1'b0) $display("FAIL err_x0_no_we: got %0b want 0", RF_WE); else pass_cnt++;
        tick();
        settle();
        total_cnt++; if (ERR !== 1'b1) $display("FAIL err_sticky: got %0b want 1", ERR); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        issue_long(20); issue_long(21);
        P_VALID = 1; P_RD = 1; P_WD = 32'h1;
        L_VALID = 1; L_RD = 20; L_WD = 32'h20;
        tick();
        L_RD = 21; L_WD = 32'h21;
        tick();
        clear_inputs();
        RST = 1;
        tick();
        RST = 0;
        ISS_VALID = 1; ISS_RS1 = 20; ISS_RD = 21;
        settle();
        total_cnt++; if (RF_WE !== 1'b0) $display("FAIL rst_mid_rf_we: got %0b want 0", RF_WE); else pass_cnt++;
        total_cnt++; if (L_READY !== 1'b1) $display("FAIL rst_mid_l_ready: got %0b want 1", L_READY); else pass_cnt++;
        total_cnt++; if (STALL !== 1'b0) $display("FAIL rst_mid_stall: got %0b want 0", STALL); else pass_cnt++;
        total_cnt++; if (ERR !== 1'b0) $display("FAIL rst_mid_err: got %0b want 0", ERR); else pass_cnt++;
        clear_inputs();
        tick();
        settle();
        total_cnt++; if (RF_WE !== 1'b0) $display("FAIL rst_mid_queue_discarded: got %0b want 0", RF_WE); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_p_vs_l();
        test_backpressure();
        test_max_out();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
